vga_plot_sink: RTL and testbench

- Far end of the plot interface that the fill and draw engines drive (vga_x, vga_y, vga_colour, vga_plot).
- Accepts plot strobes into an internal 160x120 3-bit frame memory.
- On request, reads the frame back in raster order over a valid/ready pixel stream.
- Serves as the on-chip framebuffer model for checking drawing engines, and as a readback path for the display pipeline.

---
 rtl/vga_plot_sink.sv | 218 +++++++++++++++++++++
 tb/tb_vga_plot_sink.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_plot_sink.sv
// -----------------------------------------------------------------------------
// vga_plot_sink
//
// Purpose:
//   Receiving end of the vga_x/vga_y/vga_colour/vga_plot interface that the
//   fill and draw engines drive. Each in-range plot strobe writes one 3-bit
//   pixel into an internal WIDTH x HEIGHT frame memory. A scan_start request
//   reads the whole frame back in raster order (x fastest) over a
//   valid/ready pixel stream. Plots are accepted in every state, including
//   while a readback is running.
//
// Ports:
//   clk         in   system clock, all logic on the rising edge
//   rst_n       in   asynchronous active-low reset
//   vga_x       in   [7:0] plot x coordinate
//   vga_y       in   [6:0] plot y coordinate
//   vga_colour  in   [2:0] plot colour
//   vga_plot    in   write strobe, one pixel per cycle while high
//   scan_start  in   request a full-frame readback (honoured only when idle)
//   scan_busy   out  readback in progress
//   scan_done   out  one-cycle pulse after the last pixel is accepted
//   pix_x       out  [7:0] x of the presented pixel
//   pix_y       out  [6:0] y of the presented pixel
//   pix_colour  out  [2:0] colour of the presented pixel
//   pix_valid   out  pixel presented
//   pix_ready   in   downstream accepts the presented pixel
//   plot_count  out  [14:0] saturating count of in-range plots
//                    (present only with VGA_PLOT_SINK_STATS_EN defined)
//   oob         out  sticky flag: an out-of-range plot was seen
//
// Configuration:
//   VGA_PLOT_SINK_STATS_EN  when defined, adds the plot_count output and its
//                           counter. Undefined by default.
//
// Frame memory is not reset; its contents survive rst_n.
// -----------------------------------------------------------------------------
module vga_plot_sink #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  vga_x,
  input  logic [6:0]  vga_y,
  input  logic [2:0]  vga_colour,
  input  logic        vga_plot,
  input  logic        scan_start,
  output logic        scan_busy,
  output logic        scan_done,
  output logic [7:0]  pix_x,
  output logic [6:0]  pix_y,
  output logic [2:0]  pix_colour,
  output logic        pix_valid,
  input  logic        pix_ready,
`ifdef VGA_PLOT_SINK_STATS_EN
  output logic [14:0] plot_count,
`endif
  output logic        oob
);

  localparam int          DEPTH = WIDTH * HEIGHT;
  localparam logic [7:0]  XLAST = 8'(WIDTH - 1);
  localparam logic [6:0]  YLAST = 7'(HEIGHT - 1);
  localparam logic [14:0] ROW   = 15'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_PRESENT,
    S_DONE
  } state_e;

  state_e      state_q;
  logic [7:0]  cnt_x_q;
  logic [6:0]  cnt_y_q;
  logic        busy_q;
  logic        valid_q;
  logic        done_q;
  logic [2:0]  rd_data_q;
  logic        oob_q;

  logic        plot_in_range;
  logic        plot_out_range;
  logic        start_acc;
  logic [14:0] wr_addr;
  logic [14:0] rd_addr;

  logic [2:0]  mem_q [DEPTH];

  // ---------------------------------------------------------------------------
  // Plot decode and address generation. Both operands are widened to 15 bits
  // before the multiply so y*WIDTH+x never truncates.
  // ---------------------------------------------------------------------------
  always_comb begin
    plot_in_range  = vga_plot && (vga_x <= XLAST) && (vga_y <= YLAST);
    plot_out_range = vga_plot && !((vga_x <= XLAST) && (vga_y <= YLAST));
    start_acc      = (state_q == S_IDLE) && scan_start;
    wr_addr        = 15'(vga_y) * ROW + 15'(vga_x);
    rd_addr        = 15'(cnt_y_q) * ROW + 15'(cnt_x_q);
  end

  // ---------------------------------------------------------------------------
  // Frame memory: one write port, no reset on the array.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (plot_in_range) begin
      mem_q[wr_addr] <= vga_colour;
    end
  end

  // Registered read port, loaded only in FETCH so the presented colour holds
  // while the consumer stalls. A same-cycle write to the read address lands
  // after this sample, so the old data is returned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if (state_q == S_FETCH) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  // ---------------------------------------------------------------------------
  // Readback sequencer with registered status outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_x_q <= '0;
      cnt_y_q <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (scan_start) begin
            cnt_x_q <= '0;
            cnt_y_q <= '0;
            busy_q  <= 1'b1;
            state_q <= S_FETCH;
          end
        end
        S_FETCH: begin
          valid_q <= 1'b1;
          state_q <= S_PRESENT;
        end
        S_PRESENT: begin
          if (pix_ready) begin
            valid_q <= 1'b0;
            if (cnt_x_q < XLAST) begin
              cnt_x_q <= cnt_x_q + 8'd1;
              state_q <= S_FETCH;
            end else if (cnt_y_q < YLAST) begin
              cnt_x_q <= '0;
              cnt_y_q <= cnt_y_q + 7'd1;
              state_q <= S_FETCH;
            end else begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky out-of-range flag. Setting wins over the clear from scan_start.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oob_q <= 1'b0;
    end else if (plot_out_range) begin
      oob_q <= 1'b1;
    end else if (start_acc) begin
      oob_q <= 1'b0;
    end
  end

`ifdef VGA_PLOT_SINK_STATS_EN
  // ---------------------------------------------------------------------------
  // Saturating in-range plot counter; a plot coincident with the clear
  // restarts the count at 1.
  // ---------------------------------------------------------------------------
  logic [14:0] plot_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      plot_count_q <= '0;
    end else if (start_acc) begin
      plot_count_q <= plot_in_range ? 15'd1 : 15'd0;
    end else if (plot_in_range && (plot_count_q != '1)) begin
      plot_count_q <= plot_count_q + 15'd1;
    end
  end

  assign plot_count = plot_count_q;
`endif

  assign scan_busy  = busy_q;
  assign scan_done  = done_q;
  assign pix_valid  = valid_q;
  assign pix_x      = cnt_x_q;
  assign pix_y      = cnt_y_q;
  assign pix_colour = rd_data_q;
  assign oob        = oob_q;

endmodule

// File: tb/tb_vga_plot_sink.sv
// -----------------------------------------------------------------------------
// tb_vga_plot_sink
//
// Directed sequence with randomized overwrites, out-of-range plots and
// consumer backpressure. Expected pixels come from a flat frame array indexed
// by y*160+x, updated whenever the bench plots an in-range pixel; the
// expected readback order is simply index 0..19199.
// -----------------------------------------------------------------------------
module tb_vga_plot_sink;

  localparam int W = 160;
  localparam int H = 120;
  localparam int N = W * H;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] vga_x = '0;
  logic [6:0] vga_y = '0;
  logic [2:0] vga_colour = '0;
  logic       vga_plot = 1'b0;
  logic       scan_start = 1'b0;
  logic       pix_ready = 1'b0;
  logic       scan_busy;
  logic       scan_done;
  logic [7:0] pix_x;
  logic [6:0] pix_y;
  logic [2:0] pix_colour;
  logic       pix_valid;
  logic       oob;
`ifdef VGA_PLOT_SINK_STATS_EN
  logic [14:0] plot_count;
`endif

  int errors = 0;
  int checks = 0;
  int model [N];
  int exp_idx = 0;

  always #5 clk = ~clk;

  vga_plot_sink #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .scan_start (scan_start),
    .scan_busy  (scan_busy),
    .scan_done  (scan_done),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_colour (pix_colour),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
`ifdef VGA_PLOT_SINK_STATS_EN
    .plot_count (plot_count),
`endif
    .oob        (oob)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic plot(input int x, input int y, input int c);
    vga_x      = 8'(x);
    vga_y      = 7'(y);
    vga_colour = 3'(c);
    vga_plot   = 1'b1;
    tick();
    vga_plot   = 1'b0;
    if (x < W && y < H) model[y * W + x] = c;
  endtask

  task automatic check_pixel();
    if (exp_idx < N) begin
      check("pix_x", pix_x, exp_idx % W);
      check("pix_y", pix_y, exp_idx / W);
      check("pix_colour", pix_colour, model[exp_idx]);
    end else begin
      check("extra_pixel", exp_idx, N - 1);
    end
  endtask

  // Consume pixels until pixel index 'target' is being presented.
  task automatic consume_to(input int target, input bit rnd);
    int budget;
    bit hs;
    budget = 0;
    while (!(pix_valid && exp_idx == target) && budget < 25000) begin
      if (pix_valid) check_pixel();
      pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      hs = pix_valid && pix_ready;
      tick();
      budget++;
      if (hs) exp_idx++;
    end
    check("reach_idx", exp_idx, target);
    check("reach_valid", pix_valid, 1);
  endtask

  initial begin
    int cyc;
    int first_valid;
    int done_seen;
    int done_cyc;
    bit was_valid;
    int old_c;
    int new_c;

    // ---- 1. asynchronous reset with no clock edge ----
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", scan_busy, 0);
    check("rst_done", scan_done, 0);
    check("rst_valid", pix_valid, 0);
    check("rst_oob", oob, 0);
    check("rst_pix_x", pix_x, 0);
    check("rst_pix_y", pix_y, 0);
    check("rst_pix_colour", pix_colour, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();

    // ---- 2. fill x-outer / y-inner with x%8 ----
    for (int x = 0; x < W; x++)
      for (int y = 0; y < H; y++)
        plot(x, y, x % 8);
    check("fill_oob_clear", oob, 0);

    // ---- 4. out-of-range plots ----
    plot(160, 0, 7);
    check("oob_set_x", oob, 1);
    plot(0, 120, 7);
    check("oob_set_y", oob, 1);
`ifdef VGA_PLOT_SINK_STATS_EN
    check("count_19200", plot_count, 19200);
`endif
    for (int i = 0; i < 4; i++)
      plot($urandom_range(160, 255), $urandom_range(0, 127), $urandom_range(0, 7));
    check("oob_sticky", oob, 1);

    // overwrites, named and random (random ones stay off rows 0..2 and 119)
    plot(3, 2, 5);
    plot(159, 119, 0);
    for (int i = 0; i < 30; i++)
      plot($urandom_range(0, W - 1), $urandom_range(3, H - 2), $urandom_range(0, 7));

`ifdef VGA_PLOT_SINK_STATS_EN
    // rewrite existing contents so the frame is unchanged; counter saturates
    for (int i = 0; i < 14000; i++)
      plot(i % W, i / W, model[i]);
    check("count_sat", plot_count, 32767);
`endif

    // ---- 2. full scan, pix_ready held high ----
    pix_ready  = 1'b1;
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    cyc = 1;
    check("oob_cleared", oob, 0);
    check("fetch_busy", scan_busy, 1);
    check("fetch_valid", pix_valid, 0);
`ifdef VGA_PLOT_SINK_STATS_EN
    check("count_cleared", plot_count, 0);
`endif
    exp_idx = 0;
    first_valid = 0;
    done_seen = 0;
    done_cyc = 0;
    while (cyc < 40000 && done_seen == 0) begin
      was_valid = pix_valid;
      if (pix_valid) begin
        if (first_valid == 0) first_valid = cyc;
        check_pixel();
      end
      tick();
      cyc++;
      if (was_valid) exp_idx++;
      if (scan_done) begin
        done_seen++;
        done_cyc = cyc;
      end
    end
    check("first_valid_latency", first_valid, 2);
    check("handshakes", exp_idx, N);
    check("done_cycle", done_cyc, 38401);
    check("done_busy", scan_busy, 0);
    check("done_valid", pix_valid, 0);
    tick();
    check("done_single_pulse", scan_done, 0);
    check("idle_busy", scan_busy, 0);

    // ---- 3/5. backpressure, ignored restart, reset mid-scan ----
    // an in-range plot coincident with the accepted start (same colour)
    vga_x = 8'd0; vga_y = 7'd5; vga_colour = 3'(model[5 * W]); vga_plot = 1'b1;
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    vga_plot = 1'b0;
`ifdef VGA_PLOT_SINK_STATS_EN
    check("count_clear_plus_plot", plot_count, 1);
`endif
    exp_idx = 0;
    consume_to(10, 1'b1);
    pix_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      check("bp_valid", pix_valid, 1);
      check("bp_x", pix_x, 10);
      check("bp_y", pix_y, 0);
      check("bp_colour", pix_colour, 2);
      tick();
    end
    pix_ready = 1'b1;
    tick();
    exp_idx++;
    check("resume_fetch_valid", pix_valid, 0);
    tick();
    check("resume_x", pix_x, 11);
    check_pixel();

    consume_to(30, 1'b1);
    pix_ready  = 1'b1;
    scan_start = 1'b1;
    tick();
    exp_idx++;
    tick();
    scan_start = 1'b0;
    check("restart_ignored_x", pix_x, 31);
    check("restart_ignored_busy", scan_busy, 1);

    consume_to(60 * W + 50, 1'b0);
    check("at_50_x", pix_x, 50);
    check("at_50_y", pix_y, 60);
    #2 rst_n = 1'b0;
    #1;
    check("midscan_rst_valid", pix_valid, 0);
    check("midscan_rst_busy", scan_busy, 0);
    check("midscan_rst_x", pix_x, 0);
    check("midscan_rst_y", pix_y, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();

    // ---- new scan after reset; out-of-range plot with the accepted start ----
    pix_ready  = 1'b1;
    scan_start = 1'b1;
    vga_x = 8'd200; vga_y = 7'd0; vga_colour = 3'd7; vga_plot = 1'b1;
    tick();
    scan_start = 1'b0;
    vga_plot = 1'b0;
    check("oob_with_start", oob, 1);
    exp_idx = 0;
    consume_to(4, 1'b0);
    pix_ready = 1'b1;
    tick();
    exp_idx++;
    check("rdw_fetch", pix_valid, 0);
    // write the address being read this cycle: old data must come back
    old_c = model[5];
    new_c = old_c ^ 7;
    vga_x = 8'd5; vga_y = 7'd0; vga_colour = 3'(new_c); vga_plot = 1'b1;
    tick();
    vga_plot = 1'b0;
    check("rdw_old_data", pix_colour, old_c);
    model[5] = new_c;
    check("rdw_x", pix_x, 5);
    // write a pixel ahead of the scan: new data must be read
    plot(7, 0, model[7] ^ 5);
    exp_idx++;
    consume_to(300, 1'b0);

    #2 rst_n = 1'b0;
    #1;
    check("final_rst_valid", pix_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
